// File: rtl/key_matrix_scan.sv
// key_matrix_scan: row-strobed key matrix scanner with per-key debounce; clk/i_rst_n in, o_rows strobes out, i_cols raw in, o_keys bitmap plus o_key_event/o_key_code/o_key_pressed events and o_scan_done out
module key_matrix_scan #(
  parameter int NUM_ROWS = 4,
  parameter int NUM_ROWS_WIDTH = 2,
  parameter int NUM_COLS = 4,
  parameter int KEY_CODE_WIDTH = 4,
  parameter int SCAN_DELAY = 10,
  parameter int SCAN_DELAY_WIDTH = 4,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int DEBOUNCE_WIDTH = 3,
  parameter bit ROW_OUTPUT_ACTIVE_LOW = 1,
  parameter bit COL_INPUT_ACTIVE_LOW = 1
) (
  input  logic                               clk,
  input  logic                               i_rst_n,
  output logic [NUM_ROWS-1:0]                o_rows,
  input  logic [NUM_COLS-1:0]                i_cols,
  output logic [NUM_ROWS*NUM_COLS-1:0]       o_keys,
  output logic                               o_key_event,
  output logic [KEY_CODE_WIDTH-1:0]          o_key_code,
  output logic                               o_key_pressed,
  output logic                               o_scan_done
);
  localparam int NK = NUM_ROWS * NUM_COLS;
  logic [NUM_COLS-1:0] sync1, sync2, raw;
  logic [NUM_ROWS_WIDTH-1:0] r, r_next;
  logic [SCAN_DELAY_WIDTH-1:0] d;
  logic [DEBOUNCE_WIDTH-1:0] cnt [NK];
  logic en, sample, hit;
  int base, hc;
  always_comb begin
    raw = COL_INPUT_ACTIVE_LOW ? ~sync2 : sync2;
    sample = en && d == SCAN_DELAY_WIDTH'(SCAN_DELAY - 1);
    r_next = !sample ? r : (r == NUM_ROWS_WIDTH'(NUM_ROWS - 1)) ? '0 : r + 1'b1;
    base = int'(r) * NUM_COLS;
    hit = 1'b0;
    hc = 0;
    for (int c = NUM_COLS - 1; c >= 0; c--)
      if (raw[c] != o_keys[base + c] && int'(cnt[base + c]) + 1 >= DEBOUNCE_SCANS) begin
        hit = 1'b1;
        hc = c;
      end
  end
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      r <= '0;
      d <= '0;
      en <= 1'b0;
      o_rows <= ROW_OUTPUT_ACTIVE_LOW ? '1 : '0;
      o_keys <= '0;
      o_key_event <= 1'b0;
      o_key_code <= '0;
      o_key_pressed <= 1'b0;
      o_scan_done <= 1'b0;
      for (int k = 0; k < NK; k++) cnt[k] <= '0;
    end else begin
      sync1 <= i_cols;
      sync2 <= sync1;
      en <= 1'b1;
      d <= (!en || sample) ? '0 : d + 1'b1;
      r <= r_next;
      o_rows <= ROW_OUTPUT_ACTIVE_LOW ? ~(NUM_ROWS'(1) << r_next) : NUM_ROWS'(1) << r_next;
      o_key_event <= sample && hit;
      o_scan_done <= sample && r == NUM_ROWS_WIDTH'(NUM_ROWS - 1);
      if (sample) begin
        for (int c = 0; c < NUM_COLS; c++)
          if (raw[c] == o_keys[base + c])
            cnt[base + c] <= '0;
          else if (hit && hc == c) begin
            o_keys[base + c] <= raw[c];
            cnt[base + c] <= '0;
          end else
            cnt[base + c] <= int'(cnt[base + c]) + 1 >= DEBOUNCE_SCANS ?
                             DEBOUNCE_WIDTH'(DEBOUNCE_SCANS) : cnt[base + c] + 1'b1;
        if (hit) begin
          o_key_code <= KEY_CODE_WIDTH'(base + hc);
          o_key_pressed <= raw[hc];
        end
      end
    end
  end
endmodule

// File: tb/tb_key_matrix_scan.sv
// tb_key_matrix_scan: self-checking bench with pull-up switch matrix models and an event scoreboard
module tb_key_matrix_scan;
  logic clk = 1'b0;
  logic rst_n, rst2_n;
  logic [3:0] rows1, cols1, rows2, cols2;
  logic [15:0] keys1, keys2, km, km2;
  logic ev1, ev2, pr1, pr2, done1, done2;
  logic [3:0] code1, code2;
  int n_checks = 0, n_fail = 0;
  typedef struct {logic [3:0] code; logic pressed; logic [15:0] keys;} exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  key_matrix_scan dut (.clk(clk), .i_rst_n(rst_n), .o_rows(rows1), .i_cols(cols1), .o_keys(keys1),
    .o_key_event(ev1), .o_key_code(code1), .o_key_pressed(pr1), .o_scan_done(done1));

  key_matrix_scan #(.ROW_OUTPUT_ACTIVE_LOW(0), .COL_INPUT_ACTIVE_LOW(0)) dut2 (.clk(clk), .i_rst_n(rst2_n),
    .o_rows(rows2), .i_cols(cols2), .o_keys(keys2), .o_key_event(ev2), .o_key_code(code2),
    .o_key_pressed(pr2), .o_scan_done(done2));

  always_comb begin
    cols1 = '1;
    cols2 = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        if (km[r*4+c] && !rows1[r]) cols1[c] = 1'b0;
        if (km2[r*4+c] && rows2[r]) cols2[c] = 1'b1;
      end
  end

  task automatic wait_ev(input bit sel, input int budget, output int n, output bit got);
    got = 1'b0;
    n = 0;
    while (!got && n < budget) begin
      @(posedge clk);
      #1;
      n++;
      got = sel ? ev2 : ev1;
    end
  endtask

  task automatic restart(input logic [15:0] hold);
    rst_n = 1'b0;
    km = hold;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    km = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (rows1 !== 4'b1111) begin n_fail++; $display("FAIL reset_rows got=%b exp=1111", rows1); end
    n_checks++; if (keys1 !== 16'h0) begin n_fail++; $display("FAIL reset_keys got=%h exp=0000", keys1); end
    n_checks++; if ({ev1, done1, pr1, code1} !== 7'b0) begin n_fail++; $display("FAIL reset_flags got=%b exp=0", {ev1, done1, pr1, code1}); end
  endtask

  task automatic test_scan();
    logic [3:0] er;
    bit ed;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 130; k++) begin
      @(posedge clk);
      #1;
      er = ~(4'b1 << (((k - 1) / 10) % 4));
      ed = (k % 40 == 1) && k > 1;
      n_checks++; if (rows1 !== er) begin n_fail++; $display("FAIL scan_rows edge %0d got=%b exp=%b", k, rows1, er); end
      n_checks++; if (done1 !== ed) begin n_fail++; $display("FAIL scan_done edge %0d got=%b exp=%b", k, done1, ed); end
    end
  endtask

  task automatic test_single_key();
    int n;
    bit got;
    exp_t e;
    restart(16'h0200);
    sb.push_back('{4'd9, 1'b1, 16'h0200});
    wait_ev(0, 300, n, got);
    e = sb.pop_front();
    n_checks++; if (!got || n != 151) begin n_fail++; $display("FAIL press_latency got=%0d exp=151", got ? n : -1); end
    n_checks++; if ({code1, pr1, keys1} !== {e.code, e.pressed, e.keys}) begin n_fail++; $display("FAIL press_event got=%h/%b/%h exp=%h/%b/%h", code1, pr1, keys1, e.code, e.pressed, e.keys); end
    km = '0;
    sb.push_back('{4'd9, 1'b0, 16'h0000});
    wait_ev(0, 300, n, got);
    e = sb.pop_front();
    n_checks++; if (!got || n != 160) begin n_fail++; $display("FAIL release_latency got=%0d exp=160", got ? n : -1); end
    n_checks++; if ({code1, pr1, keys1} !== {e.code, e.pressed, e.keys}) begin n_fail++; $display("FAIL release_event got=%h/%b/%h exp=%h/%b/%h", code1, pr1, keys1, e.code, e.pressed, e.keys); end
    @(posedge clk);
    #1;
    n_checks++; if (ev1 !== 1'b0) begin n_fail++; $display("FAIL event_width got=%b exp=0", ev1); end
  endtask

  task automatic test_bounce();
    int evs = 0;
    restart(16'h0080);
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk);
      #1;
      if (ev1) evs++;
      if (k == 110) km = '0;
    end
    n_checks++; if (evs != 0) begin n_fail++; $display("FAIL bounce_events got=%0d exp=0", evs); end
    n_checks++; if (keys1 !== 16'h0) begin n_fail++; $display("FAIL bounce_keys got=%h exp=0000", keys1); end
  endtask

  task automatic test_simultaneous();
    int n;
    bit got;
    exp_t e;
    restart(16'h0005);
    sb.push_back('{4'd0, 1'b1, 16'h0001});
    sb.push_back('{4'd2, 1'b1, 16'h0005});
    wait_ev(0, 300, n, got);
    e = sb.pop_front();
    n_checks++; if (!got || n != 131) begin n_fail++; $display("FAIL simul_first_latency got=%0d exp=131", got ? n : -1); end
    n_checks++; if ({code1, pr1, keys1} !== {e.code, e.pressed, e.keys}) begin n_fail++; $display("FAIL simul_first got=%h/%b/%h exp=%h/%b/%h", code1, pr1, keys1, e.code, e.pressed, e.keys); end
    wait_ev(0, 100, n, got);
    e = sb.pop_front();
    n_checks++; if (!got || n != 40) begin n_fail++; $display("FAIL simul_second_latency got=%0d exp=40", got ? n : -1); end
    n_checks++; if ({code1, pr1, keys1} !== {e.code, e.pressed, e.keys}) begin n_fail++; $display("FAIL simul_second got=%h/%b/%h exp=%h/%b/%h", code1, pr1, keys1, e.code, e.pressed, e.keys); end
  endtask

  task automatic test_reset_mid();
    int n;
    bit got;
    exp_t e;
    restart(16'h0200);
    wait_ev(0, 300, n, got);
    n_checks++; if (!got || keys1 !== 16'h0200) begin n_fail++; $display("FAIL mid_setup got=%b/%h exp=1/0200", got, keys1); end
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++; if (keys1 !== 16'h0) begin n_fail++; $display("FAIL mid_reset_keys got=%h exp=0000", keys1); end
    n_checks++; if (rows1 !== 4'b1111) begin n_fail++; $display("FAIL mid_reset_rows got=%b exp=1111", rows1); end
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back('{4'd9, 1'b1, 16'h0200});
    wait_ev(0, 300, n, got);
    e = sb.pop_front();
    n_checks++; if (!got || n != 151) begin n_fail++; $display("FAIL mid_repress_latency got=%0d exp=151", got ? n : -1); end
    n_checks++; if ({code1, pr1, keys1} !== {e.code, e.pressed, e.keys}) begin n_fail++; $display("FAIL mid_repress got=%h/%b/%h exp=%h/%b/%h", code1, pr1, keys1, e.code, e.pressed, e.keys); end
  endtask

  task automatic test_polarity();
    int n;
    bit got;
    exp_t e;
    #1;
    n_checks++; if (rows2 !== 4'b0000) begin n_fail++; $display("FAIL pol_reset_rows got=%b exp=0000", rows2); end
    km2 = 16'h0200;
    @(negedge clk);
    rst2_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (rows2 !== 4'b0001) begin n_fail++; $display("FAIL pol_first_row got=%b exp=0001", rows2); end
    sb.push_back('{4'd9, 1'b1, 16'h0200});
    wait_ev(1, 300, n, got);
    e = sb.pop_front();
    n_checks++; if (!got || n != 150) begin n_fail++; $display("FAIL pol_latency got=%0d exp=150", got ? n : -1); end
    n_checks++; if ({code2, pr2, keys2} !== {e.code, e.pressed, e.keys}) begin n_fail++; $display("FAIL pol_event got=%h/%b/%h exp=%h/%b/%h", code2, pr2, keys2, e.code, e.pressed, e.keys); end
  endtask

  initial begin
    rst_n = 1'b0;
    rst2_n = 1'b0;
    km = '0;
    km2 = '0;
    test_reset();
    test_scan();
    test_single_key();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    test_polarity();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/key_matrix_scan.md
# key_matrix_scan

Row-strobed key-matrix scanner that reads a passive switch matrix, the input-side counterpart of the LED multiplexer. It drives one row active at a time, samples the column inputs after a settling delay, debounces every key independently, and reports a debounced key bitmap plus one-cycle press/release events. It sits between the board's keypad pins and control logic, in the same clock domain as the display mux.

## Interface

- NUM_ROWS, 4, number of matrix rows driven
- NUM_ROWS_WIDTH, 2, width of row index, ceil(log2(NUM_ROWS))
- NUM_COLS, 4, number of column inputs read
- KEY_CODE_WIDTH, 4, width of key code, ceil(log2(NUM_ROWS*NUM_COLS))
- SCAN_DELAY, 10, clocks each row stays active (must be ≥4)
- SCAN_DELAY_WIDTH, 4, width of dwell counter
- DEBOUNCE_SCANS, 4, consecutive differing samples required to commit a change (≥1)
- DEBOUNCE_WIDTH, 3, width of per-key debounce counter (holds DEBOUNCE_SCANS)
- ROW_OUTPUT_ACTIVE_LOW, 1, 1: active row driven 0, others 1
- COL_INPUT_ACTIVE_LOW, 1, 1: column reads 0 when key closed

- clk  input  1  system clock
- i_rst_n  input  1  reset, asynchronous, active-low
- o_rows  output  NUM_ROWS  row strobes, one-hot active
- i_cols  input  NUM_COLS  raw column pins, asynchronous
- o_keys  output  NUM_ROWS*NUM_COLS  debounced state, bit r*NUM_COLS+c = key (r,c) pressed (always active-high)
- o_key_event  output  1  one-cycle pulse: a key's debounced state changed
- o_key_code  output  KEY_CODE_WIDTH  r*NUM_COLS+c of the changed key, valid with o_key_event
- o_key_pressed  output  1  1 = press, 0 = release, valid with o_key_event
- o_scan_done  output  1  one-cycle pulse after the last row is sampled

## Operation

- i_cols pass through a 2-flop synchronizer, then polarity-normalised to active-high.
- Row counter r (0..NUM_ROWS-1, wraps to 0) and dwell counter d (0..SCAN_DELAY-1). Row r driven active while d counts; at d = SCAN_DELAY-1 the synchronized columns are sampled for row r, d returns to 0, r advances. No blanking cycle between rows.
- Per key: stable bit (= o_keys bit) and counter cnt. On its row's sample:
  - raw == stable: cnt ← 0.
  - raw != stable and cnt+1 ≥ DEBOUNCE_SCANS and column c is the lowest-index column in this row meeting that condition: commit (stable toggles, cnt ← 0, event issued).
  - otherwise: cnt ← min(cnt+1, DEBOUNCE_SCANS).
- At most one event per row sample; deferred keys stay saturated and commit on later visits, lowest column first. No event is ever lost while the raw state persists.
- Event: o_key_code = r*NUM_COLS+c, o_key_pressed = new stable value.

## Timing

- Reset (asynchronous, immediate): o_rows all inactive (all 1s when ROW_OUTPUT_ACTIVE_LOW=1, all 0s otherwise); o_keys, o_key_event, o_key_code, o_key_pressed, o_scan_done = 0; r, d, all cnt, synchronizer = 0.
- First rising edge after i_rst_n deasserts: row 0 becomes active. Each row active exactly SCAN_DELAY cycles; full scan = NUM_ROWS*SCAN_DELAY cycles.
- Sampled value reflects i_cols ≥2 cycles earlier; columns must settle within SCAN_DELAY-3 cycles of the row change.
- o_key_event, o_key_code, o_key_pressed, o_keys update and o_scan_done pulses on the clock edge following the sample cycle (registered, 1-cycle latency).
- Press latency: DEBOUNCE_SCANS consecutive row-samples of the closed key, then 1 cycle.
- Reset mid-scan discards all debounce history; held keys re-debounce from zero.

## Test plan

Defaults; bench models switch matrix with pull-ups (column low iff key closed and its row low).
- Reset/scan: i_rst_n low → o_rows=4'b1111, o_keys=0; release → 1110 for 10 cycles, then 1101, 1011, 0111, repeat; o_scan_done every 40 cycles.
- Single key (2,1) held from reset → o_key_event with code 9, pressed 1, o_keys=16'h0200 one cycle after 4th row-2 sample; release → code 9, pressed 0 after 4 further scans.
- Bounce: key (1,3) closed for 3 row-1 samples then open → no event, o_keys stays 0.
- Simultaneous: (0,0) and (0,2) closed together → code 0 pressed on scan 4, code 2 pressed on scan 5; o_keys=16'h0005.
- Reset mid-operation: key 9 debounced, i_rst_n pulsed low mid-dwell → o_keys=0 and rows inactive immediately; with key still held, code 9 press event again after 4 scans.
- Polarity: ROW_OUTPUT_ACTIVE_LOW=0, COL_INPUT_ACTIVE_LOW=0 → reset rows 4'b0000, first active 4'b0001; active-high closed key produces the same events.
